apb_dpmem_param: RTL and testbench
==================================

Name: apb_dpmem_param

Overview:
- Parametrised successor to the APB4 dual-port memory slave.
- Port A is an APB4 completer with programmable read/write wait states, a parametrised read-only window, out-of-range error response and byte strobes.
- Port B is a native single-cycle req/gnt port, used by DMA or the boot loader, for preload and backdoor access.
- The block sits behind the APB decoder as the system scratch/config RAM.

Parameters:
- ADDR_WIDTH, 8: PADDR/b_addr width. Addresses are word indices.
- DATA_WIDTH, 32: data width; must be a multiple of 8. STRB_WIDTH = DATA_WIDTH/8.
- DEPTH, 256: number of words; must be ≤ 2**ADDR_WIDTH.
- RD_WAIT, 1: APB read wait states (PREADY low cycles in ACCESS), 0..15.
- WR_WAIT, 3: APB write wait states, 0..15.
- RO_LO, 0: first word of the APB read-only window.
- RO_HI, 15: last word of the APB read-only window (inclusive). RO_LO > RO_HI disables the window.

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  async active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_WIDTH  word address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  STRB_WIDTH  write byte strobes
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response
- b_req  in  1  port B request
- b_we  in  1  port B write
- b_addr  in  ADDR_WIDTH  port B word address
- b_wdata  in  DATA_WIDTH  port B write data
- b_be  in  STRB_WIDTH  port B byte enables
- b_gnt  out  1  port B request accepted
- b_rvalid  out  1  port B read data valid
- b_rdata  out  DATA_WIDTH  port B read data

Behaviour:
- Clock and reset: one clock, PCLK. Reset is asynchronous and active-low (PRESETn).
- Reset values: state IDLE, wait counter 0, PREADY 0, PSLVERR 0, PRDATA 0, b_gnt 0, b_rvalid 0, b_rdata 0. Memory contents are not reset.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP on PSEL & !PENABLE.
  - SETUP → ACCESS on PSEL & PENABLE.
  - ACCESS holds until PREADY. Then → SETUP if PSEL & !PENABLE, else → IDLE.
- Wait counter: loaded in SETUP with RD_WAIT or WR_WAIT per PWRITE. Decrements each ACCESS cycle while nonzero. PREADY = (state==ACCESS) & (cnt==0). A zero-wait transfer takes 2 cycles (SETUP + ACCESS).
- Error transfers: PADDR ≥ DEPTH, or a write with RO_LO ≤ PADDR ≤ RO_HI.
  - Wait counter is bypassed: PREADY = 1 and PSLVERR = 1 in the first ACCESS cycle.
  - Memory is unchanged. PRDATA = 0.
- Write commit: on the PCLK edge with ACCESS & PREADY & PWRITE & !error. Only lanes with PSTRB[i] = 1 are written. PSTRB = 0 completes OKAY with no change.
- Read: PRDATA = MEM[PADDR] while ACCESS & PREADY & !PWRITE. Otherwise PRDATA = 0.
- PSLVERR is 0 outside ACCESS & PREADY.
- Port B grant: b_gnt = b_req & !(APB write commit this cycle to the same word).
  - The requester holds b_req and all b_* inputs until b_gnt.
- Port B write: on b_req & b_gnt & b_we, lanes with b_be set are written. The RO window is ignored. b_addr ≥ DEPTH is dropped silently.
- Port B read: on b_req & b_gnt & !b_we, b_rdata is registered and b_rvalid = 1 for exactly one cycle on the next edge. b_addr ≥ DEPTH returns 0.
- Simultaneous access:
  - APB read and port B write to the same word in the same cycle: APB returns the pre-write value.
  - Port B read during an APB commit to a different word: returns the current value.
- Mid-transfer deassertion: if PSEL drops during ACCESS before PREADY, the FSM returns to IDLE next cycle and nothing is committed.
- Reset asserted mid-transfer: state, counter and outputs take reset values immediately. A pending write is never committed.

Optional Feature:
- Macro: APB_DPMEM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane and updated on every lane write from either port.
  - Extra port b_perr_inject (in, 1): when high on a port B write, the written lanes store inverted parity.
  - Extra port b_perr (out, 1): valid with b_rvalid.
  - An APB read hitting any lane with bad parity completes with PSLVERR = 1, and PRDATA is still driven with the stored data.
  - A port B read with bad parity sets b_perr = 1 alongside b_rvalid.
- When undefined: no parity storage and no extra ports. APB reads never error on data content.

Test Plan:
- Reset, then APB write 0xDEADBEEF to word 0x20 with PSTRB = 0xF → PREADY rises after exactly 3 wait cycles (WR_WAIT = 3), PSLVERR = 0. APB read of 0x20 → PREADY after 1 wait, PRDATA = 0xDEADBEEF.
- Port B writes 0x11223344 to word 0x05. APB write to 0x05 → PREADY in the first ACCESS cycle, PSLVERR = 1. APB read of 0x05 returns 0x11223344, PSLVERR = 0.
- APB write 0xAABBCCDD with PSTRB = 4'b0101 over 0x00000000 at word 0x40 → readback 0x00BB00DD. APB read of PADDR = 0x100 with DEPTH = 256 → PSLVERR = 1, PRDATA = 0.
- Hold b_req/b_we to word 0x30 while an APB write commits to 0x30 → b_gnt = 0 that cycle, 1 the next. Final value equals the port B data.
- Back-to-back APB reads without IDLE (PSEL held, second SETUP right after PREADY) → both complete with correct data. Assert PRESETn low during write ACCESS wait → word unchanged, PREADY = 0 immediately.
- With APB_DPMEM_PARITY_EN: port B write to 0x50 with b_perr_inject = 1 → APB read of 0x50 gives PSLVERR = 1. Port B read of 0x50 gives b_rvalid = 1 and b_perr = 1 one cycle after the grant.

Source files
------------

// File: rtl/apb_dpmem_param.sv
// Dual-port scratch RAM. Port A is an APB4 completer (wait states, RO window, error
// response, byte strobes). Port B is a single-cycle req/gnt port. APB_DPMEM_PARITY_EN adds lane parity.
module apb_dpmem_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 3,
  parameter int RO_LO      = 0,
  parameter int RO_HI      = 15,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [STRB_WIDTH-1:0] b_be,
`ifdef APB_DPMEM_PARITY_EN
  input  logic                  b_perr_inject,
  output logic                  b_perr,
`endif
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_W = 4'(RD_WAIT);
  localparam logic [3:0] WR_W = 4'(WR_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] a_word, b_word;
  logic [IW-1:0]         a_idx, b_idx;
  int                    a_num, b_num;
  logic a_oor, a_ro, a_err, a_perr, b_oor;
  logic in_access, pready, commit, b_wr, b_rd;

  assign a_num  = 32'(PADDR);
  assign b_num  = 32'(b_addr);
  assign a_idx  = PADDR[IW-1:0];
  assign b_idx  = b_addr[IW-1:0];
  assign a_oor  = a_num >= DEPTH;
  assign b_oor  = b_num >= DEPTH;
  assign a_ro   = (RO_LO <= RO_HI) && (a_num >= RO_LO) && (a_num <= RO_HI);
  assign a_err  = a_oor | (PWRITE & a_ro);
  assign a_word = a_oor ? '0 : mem[a_idx];
  assign b_word = b_oor ? '0 : mem[b_idx];

  // The SETUP state covers the first bus ACCESS cycle, so a zero-wait transfer is two bus cycles.
  assign in_access = PSEL & PENABLE & (state_q != IDLE);
  assign pready    = in_access & (a_err | (cnt_q == '0));
  assign commit    = pready & PWRITE & ~a_err;
  assign b_wr      = b_gnt & b_we & ~b_oor;
  assign b_rd      = b_gnt & ~b_we;

`ifdef APB_DPMEM_PARITY_EN
  logic [STRB_WIDTH-1:0] par [DEPTH];
  logic                  b_perr_q, b_perr_d;

  function automatic logic lane_bad(input logic [DATA_WIDTH-1:0] w, input logic [STRB_WIDTH-1:0] p);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < STRB_WIDTH; i++) bad |= (^w[i*8 +: 8]) ^ p[i];
    return bad;
  endfunction

  assign a_perr   = ~a_oor & ~PWRITE & lane_bad(a_word, par[a_idx]);
  assign b_perr_d = b_rd ? (~b_oor & lane_bad(b_word, par[b_idx])) : b_perr_q;
  assign b_perr   = b_perr_q;
`else
  assign a_perr = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
`ifdef APB_DPMEM_PARITY_EN
      b_perr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      b_rvalid_q <= b_rvalid_d;
      b_rdata_q  <= b_rdata_d;
`ifdef APB_DPMEM_PARITY_EN
      b_perr_q   <= b_perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (PSEL & ~PENABLE) state_d = SETUP;
      SETUP:   state_d = (PSEL & PENABLE & ~pready) ? ACCESS : IDLE;
      ACCESS:  if (pready | ~(PSEL & PENABLE)) state_d = (PSEL & ~PENABLE) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
    if (PSEL & ~PENABLE)               cnt_d = PWRITE ? WR_W : RD_W;
    else if (in_access & (cnt_q != '0)) cnt_d = cnt_q - 4'd1;
  end

  always_comb begin
    PREADY     = pready;
    PSLVERR    = pready & (a_err | a_perr);
    PRDATA     = (pready & ~PWRITE & ~a_err) ? a_word : '0;
    b_gnt      = PRESETn & b_req & ~(commit & (b_addr == PADDR));
    b_rvalid_d = b_rd;
    b_rdata_d  = b_rd ? b_word : b_rdata_q;
  end

  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;

  // Storage is not reset; the grant rule keeps the two ports off the same word.
  always_ff @(posedge PCLK) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (commit & PSTRB[i]) begin
        mem[a_idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
`ifdef APB_DPMEM_PARITY_EN
        par[a_idx][i] <= ^PWDATA[i*8 +: 8];
`endif
      end
      if (b_wr & b_be[i]) begin
        mem[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
`ifdef APB_DPMEM_PARITY_EN
        par[b_idx][i] <= (^b_wdata[i*8 +: 8]) ^ b_perr_inject;
`endif
      end
    end
  end
endmodule

// File: tb/tb_apb_dpmem_param.sv
// Directed bench for apb_dpmem_param: per-cycle compare against a word-array model plus literal checks.
module tb_apb_dpmem_param;
  localparam int AW = 9, DW = 32, SW = 4, DEPTH = 256;

  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0, PRDATA;
  logic [SW-1:0] PSTRB = '0;
  logic PREADY, PSLVERR;
  logic b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0, b_rdata;
  logic [SW-1:0] b_be = '0;
  logic b_gnt, b_rvalid;
`ifdef APB_DPMEM_PARITY_EN
  logic b_perr_inject = 1'b0, b_perr;
`endif

  apb_dpmem_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_be(b_be),
`ifdef APB_DPMEM_PARITY_EN
    .b_perr_inject(b_perr_inject), .b_perr(b_perr),
`endif
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata));

  always #5 PCLK = ~PCLK;

  int npass = 0, ntot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: memory as a word array; a transfer is ready once enough ACCESS cycles have elapsed.
  logic [31:0] mdl [DEPTH];
  bit [SW-1:0] mbad [DEPTH];
  bit          active = 1'b0;
  int          acc_n = 0;
  bit          exp_rv = 1'b0, exp_pe = 1'b0;
  logic [31:0] exp_rd = '0;
  logic        m_oor, m_err, m_perr, m_rdy, m_cmt, m_gnt;

  always_comb begin
    m_oor  = PADDR >= DEPTH;
    m_err  = m_oor || (PWRITE && PADDR <= 15);
    m_perr = !m_oor && !PWRITE && (mbad[PADDR[7:0]] != '0);
    m_rdy  = PRESETn && active && PSEL && PENABLE && (m_err || acc_n >= (PWRITE ? 3 : 1));
    m_cmt  = m_rdy && PWRITE && !m_err;
    m_gnt  = PRESETn && b_req && !(m_cmt && b_addr == PADDR);
  end

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      active <= 1'b0; acc_n <= 0; exp_rv <= 1'b0; exp_rd <= '0; exp_pe <= 1'b0;
    end else begin
      exp_rv <= m_gnt && !b_we;
      if (m_gnt && !b_we) begin
        exp_rd <= (b_addr < DEPTH) ? mdl[b_addr[7:0]] : 32'h0;
        exp_pe <= (b_addr < DEPTH) && (mbad[b_addr[7:0]] != '0);
      end
      for (int i = 0; i < SW; i++) begin
        if (m_cmt && PSTRB[i]) begin
          mdl[PADDR[7:0]][i*8 +: 8] <= PWDATA[i*8 +: 8];
          mbad[PADDR[7:0]][i] <= 1'b0;
        end
        if (m_gnt && b_we && b_addr < DEPTH && b_be[i]) begin
          mdl[b_addr[7:0]][i*8 +: 8] <= b_wdata[i*8 +: 8];
`ifdef APB_DPMEM_PARITY_EN
          mbad[b_addr[7:0]][i] <= b_perr_inject;
`else
          mbad[b_addr[7:0]][i] <= 1'b0;
`endif
        end
      end
      if (PSEL && !PENABLE) begin active <= 1'b1; acc_n <= 0; end
      else if (PSEL && PENABLE && active) begin
        if (m_rdy) active <= 1'b0;
        else acc_n <= acc_n + 1;
      end else active <= 1'b0;
    end
  end

  always @(negedge PCLK) begin
    chk("cmp PREADY", PREADY, m_rdy);
    chk("cmp PSLVERR", PSLVERR, m_rdy && (m_err || m_perr));
    chk("cmp PRDATA", PRDATA, (m_rdy && !PWRITE && !m_err) ? mdl[PADDR[7:0]] : 32'h0);
    chk("cmp b_gnt", b_gnt, m_gnt);
    chk("cmp b_rvalid", b_rvalid, PRESETn ? exp_rv : 1'b0);
    chk("cmp b_rdata", b_rdata, PRESETn ? exp_rd : 32'h0);
`ifdef APB_DPMEM_PARITY_EN
    chk("cmp b_perr", b_perr, PRESETn ? exp_pe : 1'b0);
`endif
  end

  // Tasks start and end one time unit after a rising edge.
  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input bit keep, output logic [31:0] rd, output logic err, output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    waits = 0; rd = '0; err = 1'b0;
    while (1) begin
      @(negedge PCLK);
      if (PREADY) begin rd = PRDATA; err = PSLVERR; break; end
      waits++;
      if (waits > 32) begin
        ntot++; $display("FAIL apb timeout: no PREADY after %0d cycles, limit 32", waits); break;
      end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    if (!keep) begin PSEL = 1'b0; PENABLE = 1'b0; end
  endtask

  task automatic bop(input bit we, input logic [AW-1:0] a, input logic [31:0] wd, input bit inj,
                     output int stalls, output logic rv, output logic [31:0] rd, output logic pe);
    b_req = 1'b1; b_we = we; b_addr = a; b_wdata = wd; b_be = 4'hF;
`ifdef APB_DPMEM_PARITY_EN
    b_perr_inject = inj;
`endif
    stalls = 0;
    while (1) begin
      @(negedge PCLK);
      if (b_gnt) break;
      stalls++;
      if (stalls > 32) begin
        ntot++; $display("FAIL b timeout: no b_gnt after %0d cycles, limit 32", stalls); break;
      end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    b_req = 1'b0; b_we = 1'b0;
    rv = b_rvalid; rd = b_rdata;
`ifdef APB_DPMEM_PARITY_EN
    b_perr_inject = 1'b0; pe = b_perr;
`else
    pe = 1'b0;
    if (inj) pe = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, brd;
    logic err, rv, pe;
    int w, st;
    b_req = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("rst PREADY", PREADY, 0);
    chk("rst PSLVERR", PSLVERR, 0);
    chk("rst PRDATA", PRDATA, 0);
    chk("rst b_gnt", b_gnt, 0);
    chk("rst b_rvalid", b_rvalid, 0);
    @(posedge PCLK); #1 PRESETn = 1'b1; b_req = 1'b0;

    for (int i = 0; i < DEPTH; i++) bop(1'b1, 9'(i), i * 32'h01010101, 1'b0, st, rv, brd, pe);

    apb(1'b1, 9'h020, 32'hDEADBEEF, 4'hF, 1'b0, rd, err, w);
    chk("wr20 waits", w, 3); chk("wr20 err", err, 0);
    apb(1'b0, 9'h020, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("rd20 waits", w, 1); chk("rd20 data", rd, 32'hDEADBEEF); chk("rd20 err", err, 0);

    bop(1'b1, 9'h005, 32'h11223344, 1'b0, st, rv, brd, pe);
    apb(1'b1, 9'h005, 32'hFFFFFFFF, 4'hF, 1'b0, rd, err, w);
    chk("ro05 waits", w, 0); chk("ro05 err", err, 1);
    apb(1'b0, 9'h005, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("rd05 data", rd, 32'h11223344); chk("rd05 err", err, 0);

    bop(1'b1, 9'h040, 32'h0, 1'b0, st, rv, brd, pe);
    apb(1'b1, 9'h040, 32'hAABBCCDD, 4'b0101, 1'b0, rd, err, w);
    apb(1'b0, 9'h040, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("strb40 data", rd, 32'h00BB00DD);
    apb(1'b0, 9'h100, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("oor err", err, 1); chk("oor data", rd, 0); chk("oor waits", w, 0);

    fork
      apb(1'b1, 9'h030, 32'hCAFEF00D, 4'hF, 1'b0, rd, err, w);
      begin repeat (4) @(posedge PCLK); #1 bop(1'b1, 9'h030, 32'h0BADC0DE, 1'b0, st, rv, brd, pe); end
    join
    chk("conflict stalls", st, 1);
    apb(1'b0, 9'h030, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("conflict final", rd, 32'h0BADC0DE);

    apb(1'b0, 9'h020, 32'h0, 4'h0, 1'b1, rd, err, w);
    chk("b2b first", rd, 32'hDEADBEEF);
    apb(1'b0, 9'h005, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("b2b second", rd, 32'h11223344); chk("b2b waits", w, 1);

    apb(1'b1, 9'h020, 32'h55555555, 4'h0, 1'b0, rd, err, w);
    chk("strb0 err", err, 0);
    bop(1'b0, 9'h020, 32'h0, 1'b0, st, rv, brd, pe);
    chk("brd20 valid", rv, 1); chk("brd20 data", brd, 32'hDEADBEEF);
    bop(1'b0, 9'h1FF, 32'h0, 1'b0, st, rv, brd, pe);
    chk("brd oor valid", rv, 1); chk("brd oor data", brd, 0);

    fork
      apb(1'b0, 9'h020, 32'h0, 4'h0, 1'b0, rd, err, w);
      begin repeat (2) @(posedge PCLK); #1 bop(1'b1, 9'h020, 32'h12345678, 1'b0, st, rv, brd, pe); end
    join
    chk("rd vs bwr old", rd, 32'hDEADBEEF);
    apb(1'b0, 9'h020, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("rd vs bwr new", rd, 32'h12345678);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h021; PWDATA = 32'h77777777; PSTRB = 4'hF;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    apb(1'b0, 9'h021, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("drop21 data", rd, 32'h21212121);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h020; PWDATA = 32'h99999999; PSTRB = 4'hF;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #2 PRESETn = 1'b0;
    #1 chk("rstmid PREADY", PREADY, 0);
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    apb(1'b0, 9'h020, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("rstmid data", rd, 32'h12345678);

`ifdef APB_DPMEM_PARITY_EN
    bop(1'b1, 9'h050, 32'h12345678, 1'b1, st, rv, brd, pe);
    apb(1'b0, 9'h050, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("par50 err", err, 1); chk("par50 data", rd, 32'h12345678);
    bop(1'b0, 9'h050, 32'h0, 1'b0, st, rv, brd, pe);
    chk("par50 b_rvalid", rv, 1); chk("par50 b_perr", pe, 1);
`endif

    repeat (2) @(posedge PCLK);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
